// File: rtl/regfile_pkg.sv
// Shared types and helpers for the integer register file: clear-sequencer states,
// address-width derivation and the default data width.
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Index width for a register count; never narrower than one bit.
  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port of the register file: zero/range gating, write-to-read bypass and
// an optional output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clearing,
  input  logic [AW-1:0]   raddr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            we_eff,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic            addr_ok;
  logic [XLEN-1:0] rdata_next;

  assign addr_ok = {1'b0, raddr} < (AW + 1)'(NREGS);

  // we_eff already excludes clearing, x0 and out-of-range writes.
  always_comb begin
    rdata_next = mem_data;
    if (clearing || !addr_ok || (ZERO_REG != 0 && raddr == '0)) begin
      rdata_next = '0;
    end else if (BYPASS != 0 && we_eff && waddr == raddr) begin
      rdata_next = wdata;
    end
  end

  generate
    if (READ_LAT != 0) begin : g_reg
      logic [XLEN-1:0] rdata_reg;
      always_ff @(posedge clk) begin
        if (rst) rdata_reg <= '0;
        else     rdata_reg <= rdata_next;
      end
      assign rdata = rdata_reg;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign rdata = rdata_next;
    end
  endgenerate

endmodule

// File: rtl/regfile_2r1w_clr.sv
// Two-read/one-write integer register file with hardwired-zero x0 option and a
// sequencer that zeroes one entry per cycle after reset or on request.
module regfile_2r1w_clr
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_req,
  output logic            clr_busy,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr0,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1
);

  clr_state_e      state_reg, state_next;
  logic [AW-1:0]   clr_idx_reg, clr_idx_next;
  logic [XLEN-1:0] mem [NREGS];

  logic            clearing;
  logic            waddr_ok;
  logic            we_eff;
  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [XLEN-1:0] mem_wdata;

  assign clearing = (state_reg == CLEAR);
  assign clr_busy = clearing;
  assign waddr_ok = {1'b0, waddr} < (AW + 1)'(NREGS);
  assign we_eff   = !clearing && we && waddr_ok && !(ZERO_REG != 0 && waddr == '0);

  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next   = CLEAR;
          clr_idx_next = '0;
        end
      end
      CLEAR: begin
        if (clr_idx_reg == AW'(NREGS - 1)) begin
          state_next   = IDLE;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx_reg + 1'b1;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
    end
  end

  // Single write port shared by the sequencer and writeback keeps the array RAM-friendly.
  assign mem_we    = clearing || we_eff;
  assign mem_widx  = clearing ? clr_idx_reg : waddr;
  assign mem_wdata = clearing ? '0 : wdata;

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_widx] <= mem_wdata;
  end

  logic [AW-1:0]   raddr_arr [2];
  logic [XLEN-1:0] rdata_arr [2];

  assign raddr_arr[0] = raddr0;
  assign raddr_arr[1] = raddr1;
  assign rdata0       = rdata_arr[0];
  assign rdata1       = rdata_arr[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [AW-1:0]   rd_idx;
      logic [XLEN-1:0] mem_rd;

      // Out-of-range indices are steered to entry 0; the port masks the result anyway.
      assign rd_idx = ({1'b0, raddr_arr[gi]} < (AW + 1)'(NREGS)) ? raddr_arr[gi] : '0;
      assign mem_rd = mem[rd_idx];

      regfile_rd_port #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .AW      (AW),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS),
        .READ_LAT(READ_LAT)
      ) u_rd_port (
        .clk     (clk),
        .rst     (rst),
        .clearing(clearing),
        .raddr   (raddr_arr[gi]),
        .mem_data(mem_rd),
        .we_eff  (we_eff),
        .waddr   (waddr),
        .wdata   (wdata),
        .rdata   (rdata_arr[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Drives three register-file configurations with shared stimulus and checks each
// against a behavioural array model of the register file.
module tb_regfile_2r1w_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [4:0]  raddr0 = '0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] wdata = '0;

  logic        busy_w [3];
  logic [31:0] rd0_w  [3];
  logic [31:0] rd1_w  [3];

  int total = 0;
  int bad   = 0;

  // Instance configurations: 0 = default, 1 = 24 regs registered reads, 2 = no x0, no bypass.
  int nregs [3] = '{32, 24, 32};
  int zr    [3] = '{1, 1, 0};
  int byp   [3] = '{1, 1, 0};
  int lat   [3] = '{0, 1, 0};

  logic [31:0] mdl_mem [3][64];
  int          clr_left [3];
  logic [31:0] mdl_rq0 [3];
  logic [31:0] mdl_rq1 [3];

  always #5 clk = ~clk;

  regfile_2r1w_clr #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1), .READ_LAT(0)) u0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy_w[0]), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_w[0]), .rdata1(rd1_w[0])
  );

  regfile_2r1w_clr #(.XLEN(32), .NREGS(24), .ZERO_REG(1), .BYPASS(1), .READ_LAT(1)) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy_w[1]), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_w[1]), .rdata1(rd1_w[1])
  );

  regfile_2r1w_clr #(.XLEN(32), .NREGS(32), .ZERO_REG(0), .BYPASS(0), .READ_LAT(0)) u2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy_w[2]), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_w[2]), .rdata1(rd1_w[2])
  );

  // Value a read of index ra should produce this cycle, before any output register.
  function automatic logic [31:0] exp_comb(int k, logic [4:0] ra);
    if (clr_left[k] > 0) return '0;
    if (int'(ra) >= nregs[k]) return '0;
    if (zr[k] != 0 && ra == 0) return '0;
    if (byp[k] != 0 && we && waddr == ra) return wdata;
    return mdl_mem[k][ra];
  endfunction

  function automatic logic [31:0] exp_out(int k, int port);
    if (lat[k] != 0) return (port == 0) ? mdl_rq0[k] : mdl_rq1[k];
    return exp_comb(k, (port == 0) ? raddr0 : raddr1);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void update_model();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        clr_left[k] = nregs[k];
        mdl_rq0[k]  = '0;
        mdl_rq1[k]  = '0;
      end else begin
        mdl_rq0[k] = exp_comb(k, raddr0);
        mdl_rq1[k] = exp_comb(k, raddr1);
        if (clr_left[k] > 0) begin
          mdl_mem[k][nregs[k] - clr_left[k]] = '0;
          clr_left[k] = clr_left[k] - 1;
        end else begin
          if (we && int'(waddr) < nregs[k] && !(zr[k] != 0 && waddr == 0))
            mdl_mem[k][waddr] = wdata;
          if (clr_req) clr_left[k] = nregs[k];
        end
      end
    end
  endfunction

  task automatic tick();
    update_model();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int cnt [3];
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (busy_w[k] !== 1'b1 || rd0_w[k] !== 32'h0 || rd1_w[k] !== 32'h0) begin
        bad++;
        $display("FAIL reset_state inst%0d busy=%b rd0=%h rd1=%h want busy=1 rd0=0 rd1=0", k, busy_w[k], rd0_w[k], rd1_w[k]);
      end
      cnt[k] = 0;
    end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (busy_w[k] !== (clr_left[k] > 0)) begin
          bad++;
          $display("FAIL reset_busy inst%0d cyc%0d got=%b want=%b", k, c, busy_w[k], clr_left[k] > 0);
        end
        if (busy_w[k] === 1'b1) cnt[k]++;
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cnt[k] != nregs[k]) begin
        bad++;
        $display("FAIL reset_busy_len inst%0d got=%0d want=%0d", k, cnt[k], nregs[k]);
      end
    end
    for (int i = 0; i < 33; i++) begin
      raddr0 = 5'(i);
      raddr1 = 5'(31 - i);
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (rd0_w[k] !== 32'h0 || rd1_w[k] !== 32'h0) begin
          bad++;
          $display("FAIL cleared_read inst%0d idx%0d rd0=%h rd1=%h want 0", k, i, rd0_w[k], rd1_w[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr0 = 5'd0; raddr1 = 5'd0;
    tick();
    we = 1'b1; waddr = 5'd0; wdata = 32'h1; raddr0 = 5'd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (rd0_w[k] !== exp_out(k, 0) || rd1_w[k] !== exp_out(k, 1)) begin
          bad++;
          $display("FAIL write_read inst%0d cyc%0d rd0=%h rd1=%h want rd0=%h rd1=%h", k, c, rd0_w[k], rd1_w[k], exp_out(k, 0), exp_out(k, 1));
        end
      end
      tick();
      we = 1'b0;
    end
    #1;
    total++;
    if (rd0_w[0] !== 32'hDEADBEEF || rd1_w[0] !== 32'h0 || rd1_w[2] !== 32'h1) begin
      bad++;
      $display("FAIL write_read_const u0.rd0=%h u0.rd1=%h u2.rd1=%h want deadbeef 0 1", rd0_w[0], rd1_w[0], rd1_w[2]);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'h55; raddr0 = 5'd0;
    tick();
    wdata = 32'h1234; raddr0 = 5'd7;
    #1;
    total++;
    if (rd0_w[0] !== 32'h1234 || rd0_w[2] !== 32'h55 || rd0_w[1] !== exp_out(1, 0)) begin
      bad++;
      $display("FAIL bypass_same u0=%h u2=%h u1=%h want 1234 55 %h", rd0_w[0], rd0_w[2], rd0_w[1], exp_out(1, 0));
    end
    tick();
    we = 1'b0;
    #1;
    total++;
    if (rd0_w[0] !== 32'h1234 || rd0_w[1] !== 32'h1234 || rd0_w[2] !== 32'h1234) begin
      bad++;
      $display("FAIL bypass_next u0=%h u1=%h u2=%h want 1234", rd0_w[0], rd0_w[1], rd0_w[2]);
    end
    tick();
  endtask

  task automatic test_clear();
    int cnt [3];
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i * 3);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 33; i++) begin
      raddr0 = 5'(i); raddr1 = 5'(i + 3);
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (rd0_w[k] !== exp_out(k, 0) || rd1_w[k] !== exp_out(k, 1)) begin
          bad++;
          $display("FAIL fill_read inst%0d idx%0d rd0=%h rd1=%h want %h %h", k, i, rd0_w[k], rd1_w[k], exp_out(k, 0), exp_out(k, 1));
        end
      end
      tick();
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    for (int c = 0; c < 40; c++) begin
      we = (c < 24); waddr = 5'($urandom_range(1, 31)); wdata = $urandom;
      clr_req = (c == 5);
      raddr0 = 5'($urandom_range(0, 31)); raddr1 = 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (busy_w[k] !== (clr_left[k] > 0) || rd0_w[k] !== exp_out(k, 0) || rd1_w[k] !== exp_out(k, 1)) begin
          bad++;
          $display("FAIL clear_run inst%0d cyc%0d busy=%b rd0=%h rd1=%h want %b %h %h", k, c, busy_w[k], rd0_w[k], rd1_w[k], clr_left[k] > 0, exp_out(k, 0), exp_out(k, 1));
        end
        if (busy_w[k] === 1'b1) cnt[k]++;
      end
      tick();
    end
    we = 1'b0; clr_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cnt[k] != nregs[k]) begin
        bad++;
        $display("FAIL clear_busy_len inst%0d got=%0d want=%0d", k, cnt[k], nregs[k]);
      end
    end
    for (int i = 0; i < 33; i++) begin
      raddr0 = 5'(i); raddr1 = 5'(i);
      #1;
      total++;
      if (rd0_w[0] !== 32'h0 || rd1_w[2] !== 32'h0 || rd0_w[1] !== exp_out(1, 0)) begin
        bad++;
        $display("FAIL clear_after idx%0d u0=%h u2=%h u1=%h want 0 0 %h", i, rd0_w[0], rd1_w[2], rd0_w[1], exp_out(1, 0));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt [3];
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (busy_w[k] !== (clr_left[k] > 0)) begin
          bad++;
          $display("FAIL midclr_busy inst%0d cyc%0d got=%b want=%b", k, c, busy_w[k], clr_left[k] > 0);
        end
        if (busy_w[k] === 1'b1) cnt[k]++;
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cnt[k] != nregs[k]) begin
        bad++;
        $display("FAIL midclr_busy_len inst%0d got=%0d want=%0d", k, cnt[k], nregs[k]);
      end
    end
  endtask

  task automatic test_range();
    we = 1'b1; waddr = 5'd30; wdata = 32'hA5A5A5A5;
    tick();
    waddr = 5'd23; wdata = 32'h23232323;
    tick();
    we = 1'b0; raddr0 = 5'd30; raddr1 = 5'd23;
    tick();
    #1;
    total++;
    if (rd0_w[1] !== 32'h0 || rd1_w[1] !== 32'h23232323) begin
      bad++;
      $display("FAIL range_n24 rd0=%h rd1=%h want 0 23232323", rd0_w[1], rd1_w[1]);
    end
    total++;
    if (rd0_w[0] !== 32'hA5A5A5A5 || rd1_w[0] !== 32'h23232323) begin
      bad++;
      $display("FAIL range_n32 rd0=%h rd1=%h want a5a5a5a5 23232323", rd0_w[0], rd1_w[0]);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      we = $urandom_range(0, 1) == 1;
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      raddr0 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr1 = ($urandom_range(0, 3) == 0) ? raddr0 : 5'($urandom_range(0, 31));
      clr_req = ($urandom_range(0, 99) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (busy_w[k] !== (clr_left[k] > 0) || rd0_w[k] !== exp_out(k, 0) || rd1_w[k] !== exp_out(k, 1)) begin
          bad++;
          $display("FAIL random inst%0d cyc%0d busy=%b rd0=%h rd1=%h want %b %h %h", k, c, busy_w[k], rd0_w[k], rd1_w[k], clr_left[k] > 0, exp_out(k, 0), exp_out(k, 1));
        end
      end
      tick();
    end
    clr_req = 1'b0; we = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      clr_left[k] = 0;
      mdl_rq0[k]  = '0;
      mdl_rq1[k]  = '0;
      for (int i = 0; i < 64; i++) mdl_mem[k][i] = '0;
    end
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    test_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time exceeded total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
